// File: rtl/id_pipe.sv
// RV32 decode stage: splits instructions into operand fields, registers them
// behind a valid/ready handshake and inserts one bubble per load-use hazard.
module id_pipe #(
    parameter int REG_AW = 5,
    parameter int RVE    = 0,
    parameter int EN_CSR = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       ins_i,
    input  logic [31:0]       ins_addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       ins_o,
    output logic [31:0]       ins_addr_o,
    output logic [REG_AW-1:0] reg1_rd_addr_o,
    output logic [REG_AW-1:0] reg2_rd_addr_o,
    output logic [REG_AW-1:0] reg_wr_addr_o,
    output logic [31:0]       imm_o,
    output logic              mem_rd_flag_o,
    output logic              mem_wr_flag_o,
    output logic [31:0]       csr_rw_addr_o,
    output logic [31:0]       csr_zimm_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    typedef struct packed {
        logic [31:0]       ins;
        logic [31:0]       addr;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [31:0]       imm;
        logic              mrd;
        logic              mwr;
        logic [31:0]       csr_a;
        logic [31:0]       zimm;
        logic              ill;
    } dec_t;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [31:0] imm_i;
    logic        u1, u2, ud, mrd, mwr, ill;
    logic [31:0] imm, csr_a, zimm;
    dec_t        dec;
    dec_t        out_q;
    logic        out_valid_q;
    logic [CNT_W-1:0] bub_q;
    logic        hazard;

    assign opcode = ins_i[6:0];
    assign f3     = ins_i[14:12];
    assign imm_i  = {{20{ins_i[31]}}, ins_i[31:20]};

    always_comb begin
        u1    = 1'b0;
        u2    = 1'b0;
        ud    = 1'b0;
        mrd   = 1'b0;
        mwr   = 1'b0;
        ill   = 1'b0;
        imm   = '0;
        csr_a = '0;
        zimm  = '0;
        unique case (1'b1)
            (opcode == OP_IMM): begin
                u1  = 1'b1;
                ud  = 1'b1;
                imm = (f3 == 3'b001 || f3 == 3'b101) ?
                      {27'h0, ins_i[24:20]} : imm_i;
            end
            (opcode == OP_REG): begin
                u1 = 1'b1;
                u2 = 1'b1;
                ud = 1'b1;
            end
            (opcode == OP_LUI),
            (opcode == OP_AUIPC): begin
                ud  = 1'b1;
                imm = {ins_i[31:12], 12'h0};
            end
            (opcode == OP_JAL): begin
                ud  = 1'b1;
                imm = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12],
                       ins_i[20], ins_i[30:21], 1'b0};
            end
            (opcode == OP_JALR): begin
                u1  = 1'b1;
                ud  = 1'b1;
                imm = imm_i;
            end
            (opcode == OP_BRANCH): begin
                u1  = 1'b1;
                u2  = 1'b1;
                imm = {{19{ins_i[31]}}, ins_i[31], ins_i[7],
                       ins_i[30:25], ins_i[11:8], 1'b0};
            end
            (opcode == OP_STORE): begin
                u1  = 1'b1;
                u2  = 1'b1;
                mwr = 1'b1;
                imm = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
            end
            (opcode == OP_LOAD): begin
                u1  = 1'b1;
                ud  = 1'b1;
                mrd = 1'b1;
                imm = imm_i;
            end
            (opcode == OP_SYS): begin
                if (EN_CSR == 0) begin
                    ill = 1'b1;
                end else if (f3 == 3'b100) begin
                    ill = 1'b1;
                end else if (f3 != 3'b000) begin
                    ud    = 1'b1;
                    u1    = ~f3[2];
                    csr_a = {20'h0, ins_i[31:20]};
                    zimm  = f3[2] ? {27'h0, ins_i[19:15]} : 32'h0;
                end
            end
            default: ill = 1'b1;
        endcase
        // RV32E only has x0..x15
        if (RVE != 0 && ((u1 && ins_i[19]) || (u2 && ins_i[24]) ||
                         (ud && ins_i[11])))
            ill = 1'b1;
    end

    always_comb begin
        dec       = '0;
        dec.ins   = ins_i;
        dec.addr  = ins_addr_i;
        dec.ill   = ill;
        if (!ill) begin
            dec.rs1   = u1 ? REG_AW'(ins_i[19:15]) : '0;
            dec.rs2   = u2 ? REG_AW'(ins_i[24:20]) : '0;
            dec.rd    = ud ? REG_AW'(ins_i[11:7]) : '0;
            dec.imm   = imm;
            dec.mrd   = mrd;
            dec.mwr   = mwr;
            dec.csr_a = csr_a;
            dec.zimm  = zimm;
        end
    end

    // Unused sources decode to x0, which can never match a nonzero rd
    assign hazard = in_valid_i & out_valid_q & out_q.mrd &
                    (out_q.rd != '0) &
                    ((dec.rs1 == out_q.rd) | (dec.rs2 == out_q.rd));

    assign in_ready_o = (~out_valid_q | out_ready_i) & ~hazard & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            bub_q       <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (hazard && out_ready_i) begin
            out_valid_q <= 1'b0;
            if (bub_q != '1)
                bub_q <= bub_q + CNT_W'(1);
        end else if (in_valid_i && in_ready_o) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign ins_o          = out_q.ins;
    assign ins_addr_o     = out_q.addr;
    assign reg1_rd_addr_o = out_q.rs1;
    assign reg2_rd_addr_o = out_q.rs2;
    assign reg_wr_addr_o  = out_q.rd;
    assign imm_o          = out_q.imm;
    assign mem_rd_flag_o  = out_q.mrd;
    assign mem_wr_flag_o  = out_q.mwr;
    assign csr_rw_addr_o  = out_q.csr_a;
    assign csr_zimm_o     = out_q.zimm;
    assign illegal_o      = out_q.ill;
    assign bubble_cnt_o   = bub_q;

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: one default instance and one RV32E instance
// share the same stimulus; expected values are hand-computed constants.
module tb_id_pipe;

    logic        clk = 1'b0;
    logic        rst, flush_i, in_valid_i, out_ready_i;
    logic [31:0] ins_i, ins_addr_i;

    logic        in_ready_o, out_valid_o, mem_rd_flag_o, mem_wr_flag_o;
    logic        illegal_o;
    logic [31:0] ins_o, ins_addr_o, imm_o, csr_rw_addr_o, csr_zimm_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [15:0] bubble_cnt_o;

    logic        r_in_ready, r_out_valid, r_mrd, r_mwr, r_illegal;
    logic [31:0] r_ins, r_ins_addr, r_imm, r_csr_a, r_zimm;
    logic [4:0]  r_rs1, r_rs2, r_rd;
    logic [15:0] r_bub;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_bub = 16'd0;

    always #5 clk = ~clk;

    id_pipe u_dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .ins_i(ins_i), .ins_addr_i(ins_addr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .ins_o(ins_o), .ins_addr_o(ins_addr_o),
        .reg1_rd_addr_o(rs1_o), .reg2_rd_addr_o(rs2_o),
        .reg_wr_addr_o(rd_o), .imm_o(imm_o),
        .mem_rd_flag_o(mem_rd_flag_o), .mem_wr_flag_o(mem_wr_flag_o),
        .csr_rw_addr_o(csr_rw_addr_o), .csr_zimm_o(csr_zimm_o),
        .illegal_o(illegal_o), .bubble_cnt_o(bubble_cnt_o)
    );

    id_pipe #(.RVE(1)) u_rve (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(r_in_ready),
        .ins_i(ins_i), .ins_addr_i(ins_addr_i),
        .out_valid_o(r_out_valid), .out_ready_i(out_ready_i),
        .ins_o(r_ins), .ins_addr_o(r_ins_addr),
        .reg1_rd_addr_o(r_rs1), .reg2_rd_addr_o(r_rs2),
        .reg_wr_addr_o(r_rd), .imm_o(r_imm),
        .mem_rd_flag_o(r_mrd), .mem_wr_flag_o(r_mwr),
        .csr_rw_addr_o(r_csr_a), .csr_zimm_o(r_zimm),
        .illegal_o(r_illegal), .bubble_cnt_o(r_bub)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        ins_i = 32'h0; ins_addr_i = 32'h0;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid_o); end
        checks++; if (bubble_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_bub got %0d exp 0", bubble_cnt_o); end
        checks++; if (imm_o !== 32'h0 || rd_o !== 5'd0 || ins_o !== 32'h0) begin errors++; $display("FAIL rst_payload got imm %h rd %0d ins %h exp 0", imm_o, rd_o, ins_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready_o); end
    endtask

    task automatic test_addi();
        in_valid_i = 1'b1; ins_i = 32'hFFF10093; ins_addr_i = 32'h0000_0040;
        step();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL addi_valid got %b exp 1", out_valid_o); end
        checks++; if (rs1_o !== 5'd2 || rs2_o !== 5'd0 || rd_o !== 5'd1) begin errors++; $display("FAIL addi_regs got %0d %0d %0d exp 2 0 1", rs1_o, rs2_o, rd_o); end
        checks++; if (imm_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h exp ffffffff", imm_o); end
        checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL addi_illegal got %b exp 0", illegal_o); end
        checks++; if (ins_addr_o !== 32'h40 || ins_o !== 32'hFFF10093) begin errors++; $display("FAIL addi_copy got %h %h exp fff10093 40", ins_o, ins_addr_o); end
        step();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL addi_drain got %b exp 0", out_valid_o); end
    endtask

    task automatic test_back_to_back();
        in_valid_i = 1'b1; ins_i = 32'hFFF10093;
        step();
        ins_i = 32'h00512423;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", in_ready_o); end
        step();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1 || mem_wr_flag_o !== 1'b1 || rd_o !== 5'd0) begin errors++; $display("FAIL b2b_sw got v %b wr %b rd %0d exp 1 1 0", out_valid_o, mem_wr_flag_o, rd_o); end
        step();
    endtask

    task automatic test_load_use();
        in_valid_i = 1'b1; ins_i = 32'h0000A283;
        step();
        checks++; if (out_valid_o !== 1'b1 || mem_rd_flag_o !== 1'b1 || rd_o !== 5'd5) begin errors++; $display("FAIL lu_load got v %b rd_flag %b rd %0d exp 1 1 5", out_valid_o, mem_rd_flag_o, rd_o); end
        ins_i = 32'h00728333;
        #1;
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL lu_hazard_ready got %b exp 0", in_ready_o); end
        step();
        exp_bub = exp_bub + 16'd1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b exp 0", out_valid_o); end
        checks++; if (bubble_cnt_o !== exp_bub) begin errors++; $display("FAIL lu_bub_cnt got %0d exp %0d", bubble_cnt_o, exp_bub); end
        step();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1 || rs1_o !== 5'd5 || rs2_o !== 5'd7 || rd_o !== 5'd6) begin errors++; $display("FAIL lu_add got v %b %0d %0d %0d exp 1 5 7 6", out_valid_o, rs1_o, rs2_o, rd_o); end
        checks++; if (mem_rd_flag_o !== 1'b0) begin errors++; $display("FAIL lu_add_mrd got %b exp 0", mem_rd_flag_o); end
        step();
    endtask

    task automatic test_x0_load();
        in_valid_i = 1'b1; ins_i = 32'h0000A003;
        step();
        ins_i = 32'h00700333;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", in_ready_o); end
        step();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1 || rd_o !== 5'd6 || bubble_cnt_o !== exp_bub) begin errors++; $display("FAIL x0_pass got v %b rd %0d bub %0d exp 1 6 %0d", out_valid_o, rd_o, bubble_cnt_o, exp_bub); end
        step();
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; ins_i = 32'h00512423;
        step();
        ins_i = 32'hFFF10093;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid_o !== 1'b1 || rs1_o !== 5'd2 || rs2_o !== 5'd5 || rd_o !== 5'd0) begin errors++; $display("FAIL bp_regs%0d got v %b %0d %0d %0d exp 1 2 5 0", i, out_valid_o, rs1_o, rs2_o, rd_o); end
            checks++; if (imm_o !== 32'd8 || mem_wr_flag_o !== 1'b1 || in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got imm %h wr %b rdy %b exp 8 1 0", i, imm_o, mem_wr_flag_o, in_ready_o); end
            step();
        end
        out_ready_i = 1'b1;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready_o); end
        step();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1 || rd_o !== 5'd1 || mem_wr_flag_o !== 1'b0) begin errors++; $display("FAIL bp_next got v %b rd %0d wr %b exp 1 1 0", out_valid_o, rd_o, mem_wr_flag_o); end
        step();
    endtask

    task automatic test_stalled_hazard();
        in_valid_i = 1'b1; ins_i = 32'h0000A283;
        step();
        out_ready_i = 1'b0;
        ins_i = 32'h00728333;
        step();
        step();
        checks++; if (out_valid_o !== 1'b1 || rd_o !== 5'd5 || bubble_cnt_o !== exp_bub) begin errors++; $display("FAIL sh_hold got v %b rd %0d bub %0d exp 1 5 %0d", out_valid_o, rd_o, bubble_cnt_o, exp_bub); end
        out_ready_i = 1'b1;
        step();
        exp_bub = exp_bub + 16'd1;
        checks++; if (out_valid_o !== 1'b0 || bubble_cnt_o !== exp_bub) begin errors++; $display("FAIL sh_bubble got v %b bub %0d exp 0 %0d", out_valid_o, bubble_cnt_o, exp_bub); end
        step();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1 || rd_o !== 5'd6) begin errors++; $display("FAIL sh_add got v %b rd %0d exp 1 6", out_valid_o, rd_o); end
        step();
    endtask

    task automatic test_csr();
        in_valid_i = 1'b1; ins_i = 32'h3002D1F3;
        step();
        in_valid_i = 1'b0;
        checks++; if (csr_rw_addr_o !== 32'h300 || csr_zimm_o !== 32'd5) begin errors++; $display("FAIL csr_fields got %h %h exp 300 5", csr_rw_addr_o, csr_zimm_o); end
        checks++; if (rs1_o !== 5'd0 || rd_o !== 5'd3 || illegal_o !== 1'b0) begin errors++; $display("FAIL csr_regs got rs1 %0d rd %0d ill %b exp 0 3 0", rs1_o, rd_o, illegal_o); end
        step();
    endtask

    task automatic test_illegal();
        in_valid_i = 1'b1; ins_i = 32'hFFFFFFFF;
        step();
        checks++; if (out_valid_o !== 1'b1 || illegal_o !== 1'b1) begin errors++; $display("FAIL ill_flag got v %b ill %b exp 1 1", out_valid_o, illegal_o); end
        checks++; if (rs1_o !== 5'd0 || rd_o !== 5'd0 || imm_o !== 32'h0 || csr_rw_addr_o !== 32'h0) begin errors++; $display("FAIL ill_zero got %0d %0d %h %h exp 0", rs1_o, rd_o, imm_o, csr_rw_addr_o); end
        checks++; if (r_illegal !== 1'b1) begin errors++; $display("FAIL rve_ill_ff got %b exp 1", r_illegal); end
        ins_i = 32'h007288B3;
        step();
        checks++; if (r_illegal !== 1'b1 || r_rd !== 5'd0 || r_rs1 !== 5'd0) begin errors++; $display("FAIL rve_x17 got ill %b rd %0d rs1 %0d exp 1 0 0", r_illegal, r_rd, r_rs1); end
        checks++; if (illegal_o !== 1'b0 || rd_o !== 5'd17) begin errors++; $display("FAIL rv32_x17 got ill %b rd %0d exp 0 17", illegal_o, rd_o); end
        ins_i = 32'h00728333;
        step();
        in_valid_i = 1'b0;
        checks++; if (r_illegal !== 1'b0 || r_rs2 !== 5'd7 || r_rd !== 5'd6) begin errors++; $display("FAIL rve_legal got ill %b rs2 %0d rd %0d exp 0 7 6", r_illegal, r_rs2, r_rd); end
        step();
    endtask

    task automatic test_flush();
        in_valid_i = 1'b1; ins_i = 32'h0000A283;
        step();
        ins_i = 32'h00728333;
        flush_i = 1'b1;
        #1;
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL fl_ready got %b exp 0", in_ready_o); end
        step();
        flush_i = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0 || bubble_cnt_o !== exp_bub) begin errors++; $display("FAIL fl_drop got v %b bub %0d exp 0 %0d", out_valid_o, bubble_cnt_o, exp_bub); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL fl_accept_ready got %b exp 1", in_ready_o); end
        step();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1 || rd_o !== 5'd6 || rs1_o !== 5'd5) begin errors++; $display("FAIL fl_add got v %b rd %0d rs1 %0d exp 1 6 5", out_valid_o, rd_o, rs1_o); end
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_load_use();
        test_x0_load();
        test_backpressure();
        test_stalled_hazard();
        test_csr();
        test_illegal();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_pipe.md
# id_pipe

Registered, handshaked RV32 instruction-decode stage between fetch and execute. It splits each instruction into register-file read addresses, a write address, a sign-extended immediate, memory read/write flags and CSR fields, and holds them in one output pipeline register. It also detects load-use hazards and inserts one bubble per hazard, supports a flush input, flags illegal encodings and counts inserted bubbles.

## Interface
- `REG_AW`, 5: width of register address outputs; upper bits above 5 are zero.
- `RVE`, 0: 1 = RV32E mode; any used rs1/rs2/rd ≥ 16 marks the instruction illegal.
- `EN_CSR`, 1: 0 = CSR opcode (1110011) decodes as illegal.
- `CNT_W`, 16: width of the saturating bubble counter.

Ports:
- `clk` in 1: clock; everything on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush_i` in 1: discard output register contents and the instruction presented this cycle.
- `in_valid_i` in 1: fetch presents an instruction.
- `in_ready_o` out 1: stage accepts this cycle.
- `ins_i` in 32: instruction word.
- `ins_addr_i` in 32: instruction address.
- `out_valid_o` out 1: decoded instruction valid.
- `out_ready_i` in 1: execute accepts.
- `ins_o`, `ins_addr_o` out 32: registered copies of the inputs.
- `reg1_rd_addr_o`, `reg2_rd_addr_o`, `reg_wr_addr_o` out REG_AW: rs1, rs2, rd; 0 when unused.
- `imm_o` out 32: immediate.
- `mem_rd_flag_o`, `mem_wr_flag_o` out 1: load / store.
- `csr_rw_addr_o` out 32: `{20'h0, ins[31:20]}` for CSR ops, else 0.
- `csr_zimm_o` out 32: `{27'h0, ins[19:15]}` for CSR immediate ops, else 0.
- `illegal_o` out 1: unsupported or illegal encoding.
- `bubble_cnt_o` out CNT_W: number of bubbles inserted.

## Operation
Decode by opcode:
- **I-ALU (0010011):** uses rs1 and rd.
  - imm = sext(ins[31:20]).
  - For funct3 001 and 101, imm = zext(ins[24:20]).
- **R (0110011):** uses rs1, rs2, rd; imm = 0.
- **LUI (0110111) / AUIPC (0010111):** uses rd; imm = {ins[31:12], 12'h0}.
- **JAL (1101111):** uses rd; imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 0}).
- **JALR (1100111):** uses rs1 and rd; I-immediate.
- **BRANCH (1100011):** uses rs1 and rs2; imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 0}).
- **STORE (0100011):** uses rs1 and rs2; imm = sext({ins[31:25], ins[11:7]}); mem_wr = 1.
- **LOAD (0000011):** uses rs1 and rd; I-immediate; mem_rd = 1.
- **CSR (1110011):**
  - funct3 001/010/011: uses rs1 and rd; sets csr_rw_addr.
  - funct3 101/110/111: uses rd; sets csr_rw_addr and zimm.
  - funct3 000: all fields 0, not illegal.
  - funct3 100: illegal.
- **Any other opcode, or an RVE violation:** illegal = 1, all address/imm/flag/CSR outputs 0. The instruction still flows through the pipe.
- **Hazard:** `hazard = in_valid & out_valid & out_mem_rd & (out_rd != 0) & ((uses_rs1 & rs1 == out_rd) | (uses_rs2 & rs2 == out_rd))`.
- **Ready:** `in_ready_o = (~out_valid | out_ready_i) & ~hazard & ~flush_i`.
- **Update priority, highest first:**
  1. rst
  2. flush_i: out_valid ← 0.
  3. hazard & out_ready_i: out_valid ← 0 (bubble); bubble_cnt += 1, saturating at all-ones.
  4. in_valid & in_ready: load the decoded instruction, out_valid ← 1.
  5. out_ready_i: out_valid ← 0.
  6. Otherwise: hold.
- Payload registers update only on load. The payload is don't-care while out_valid = 0, but it must hold stable while out_valid & ~out_ready.

## Timing
- **Reset:** on `rst` at an edge, all outputs are 0 the next cycle, including out_valid and bubble_cnt. in_ready_o = 1 once rst is low.
- **Mid-operation reset or flush:** drops any held instruction with no partial output. Flush does not clear bubble_cnt.
- **Latency:** 1 cycle from accept (in_valid & in_ready at edge N) to out_valid at N+1.
- **Throughput:** 1 instruction/cycle while out_ready_i = 1 and no hazard.
- **Backpressure:** out_valid & ~out_ready_i forces in_ready_o = 0 and freezes all outputs.
- **Load-use:** exactly one bubble cycle between a load and a dependent instruction. A dependent instruction held behind a stalled load waits without counting extra bubbles; the count increments only on the edge where out_ready_i = 1.
- **rd = x0:** a load with rd = x0 never causes a hazard.
- **Flush during hazard:** no bubble is counted, and the next instruction is accepted at the following edge.

## Test plan
- Reset, then `0xFFF10093` (addi x1,x2,-1) with out_ready = 1 → next cycle: out_valid = 1, rs1 = 2, rs2 = 0, rd = 1, imm = 0xFFFFFFFF, illegal = 0.
- `0x0000A283` (lw x5,0(x1)) then `0x00728333` (add x6,x5,x7) back-to-back, out_ready = 1:
  - lw appears at cycle 1 with mem_rd = 1.
  - out_valid = 0 at cycle 2.
  - add appears at cycle 3 with rs1 = 5, rs2 = 7, rd = 6.
  - bubble_cnt = 1.
- `0x00512423` (sw x5,8(x2)) with out_ready = 0 for 3 cycles:
  - outputs stable at rs1 = 2, rs2 = 5, rd = 0, imm = 8, mem_wr = 1; in_ready = 0.
  - Released when out_ready = 1.
- `0x3002D1F3` (csrrwi x3,0x300,5) → csr_rw_addr = 0x300, csr_zimm = 5, rs1 = 0, rd = 3.
- `0xFFFFFFFF`, then `0x00728333` in RVE = 1 mode → illegal = 1 for both (all fields 0 for the first; rs2 = 7 is legal, so use add x17 = `0x007288B3` for the second check).
- lw x5 at the output with dependent add waiting, then pulse flush_i:
  - out_valid = 0 next cycle.
  - add is accepted the following cycle.
  - bubble_cnt unchanged.
